// File: rtl/set_pkg.sv
// -----------------------------------------------------------------------------
// set_pkg
// Shared types and constants for the SET engine host.
//   - state_e      : host FSM states
//   - MODE_*       : engine mode encodings (what region is counted)
//   - *_W          : descriptor / result field widths
// -----------------------------------------------------------------------------
package set_pkg;

  localparam int COORD_W   = 4;   // one x or y coordinate, also one radius
  localparam int CENTRAL_W = 24;  // {x1,y1,x2,y2,x3,y3}
  localparam int RADIUS_W  = 12;  // {r1,r2,r3}
  localparam int MODE_W    = 2;
  localparam int COUNT_W   = 8;   // engine candidate count
  localparam int DONE_W    = 16;  // handed-off result counter

  localparam logic [MODE_W-1:0] MODE_IN_C1    = 2'd0;  // inside C1
  localparam logic [MODE_W-1:0] MODE_C1_AND_2 = 2'd1;  // C1 intersect C2
  localparam logic [MODE_W-1:0] MODE_C1_XOR_2 = 2'd2;  // C1 xor C2
  localparam logic [MODE_W-1:0] MODE_TWO_OF_3 = 2'd3;  // exactly two circles

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_BUSY  = 3'd2,
    WAIT_VALID = 3'd3,
    DRAIN      = 3'd4,
    RESULT     = 3'd5
  } state_e;

endpackage

// File: rtl/set_watchdog.sv
// -----------------------------------------------------------------------------
// set_watchdog
// Clear/enable/expire cycle counter used to abort a hung engine job.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the counter (takes priority over en)
//   en       : count one cycle
//   expired  : counter has reached TIMEOUT; it then holds there until clr
// -----------------------------------------------------------------------------
module set_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT));

  // Saturate at TIMEOUT so a host that lingers after expiry keeps seeing it.
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/set_host.sv
// -----------------------------------------------------------------------------
// set_host
// Job-issuing front end for the SET grid-candidate counting engine.
// Accepts one job descriptor at a time, starts the engine with a one-cycle
// set_en, follows the engine busy/valid handshake, and returns the captured
// count with the job tag. A watchdog turns a hung engine into a result
// flagged with res_timeout (count forced to 0).
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   job_valid/job_ready      : job descriptor handshake
//   job_central/radius/mode  : descriptor fields, job_tag returned with result
//   set_en                   : one-cycle engine start
//   set_central/radius/mode  : registered descriptor held for the engine
//   set_busy/valid/candidate : engine status and count
//   res_valid/res_ready      : result handshake
//   res_candidate/tag/timeout: result payload
//   done_cnt                 : results handed off since reset (wraps)
// -----------------------------------------------------------------------------
module set_host
  import set_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // job descriptor
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [CENTRAL_W-1:0] job_central,
  input  logic [RADIUS_W-1:0]  job_radius,
  input  logic [MODE_W-1:0]    job_mode,
  input  logic [TAG_W-1:0]     job_tag,
  // engine
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [MODE_W-1:0]    set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [COUNT_W-1:0]   set_candidate,
  // result
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [COUNT_W-1:0]   res_candidate,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_timeout,
  output logic [DONE_W-1:0]    done_cnt
);

  state_e state, state_nxt;

  logic accept;     // descriptor latched this cycle
  logic cap_valid;  // engine count captured this cycle
  logic cap_to;     // watchdog abort this cycle
  logic handoff;    // result consumed this cycle
  logic wd_clr, wd_en, wd_expired;

  set_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    job_ready = 1'b0;
    set_en    = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    cap_valid = 1'b0;
    cap_to    = 1'b0;
    handoff   = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;

    unique case (state)
      IDLE: begin
        // An engine still busy from an aborted job must finish first.
        job_ready = !set_busy;
        if (job_valid && !set_busy) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        set_en    = 1'b1;
        wd_clr    = 1'b1;
        state_nxt = WAIT_BUSY;
      end

      // set_valid is deliberately ignored until busy has been seen, so a
      // stale valid from a previous job cannot be taken as this job's count.
      WAIT_BUSY: begin
        wd_en = 1'b1;
        if (wd_expired) begin
          cap_to    = 1'b1;
          state_nxt = RESULT;
        end else if (set_busy) begin
          state_nxt = WAIT_VALID;
        end
      end

      WAIT_VALID: begin
        wd_en = 1'b1;
        if (wd_expired) begin
          cap_to    = 1'b1;
          state_nxt = RESULT;
        end else if (set_valid) begin
          cap_valid = 1'b1;
          state_nxt = DRAIN;
        end
      end

      // Hold the result back until the engine is idle again, so the next job
      // is never offered to an engine that is still winding down.
      DRAIN: begin
        wd_en = 1'b1;
        if (wd_expired) begin
          cap_to    = 1'b1;
          state_nxt = RESULT;
        end else if (!set_busy) begin
          state_nxt = RESULT;
        end
      end

      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          handoff   = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      res_tag       <= '0;
      res_candidate <= '0;
      res_timeout   <= 1'b0;
      done_cnt      <= '0;
    end else begin
      state <= state_nxt;

      // The engine samples these every cycle, so they change only here.
      if (accept) begin
        set_central <= job_central;
        set_radius  <= job_radius;
        set_mode    <= job_mode;
        res_tag     <= job_tag;
      end

      if (cap_valid) begin
        res_candidate <= set_candidate;
        res_timeout   <= 1'b0;
      end

      // An abort overrides any count already captured in DRAIN.
      if (cap_to) begin
        res_candidate <= '0;
        res_timeout   <= 1'b1;
      end

      if (handoff)
        done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_set_host.sv
// -----------------------------------------------------------------------------
// tb_set_host
// Self-checking bench for set_host. A behavioural engine stub answers set_en
// with busy/valid and a grid count computed by a reference function; the host
// results are compared against that function, fixed constants and a simple
// timing/count model.
// -----------------------------------------------------------------------------
module tb_set_host;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [23:0]      job_central = '0;
  logic [11:0]      job_radius = '0;
  logic [1:0]       job_mode = '0;
  logic [TAG_W-1:0] job_tag = '0;
  logic             set_en;
  logic [23:0]      set_central;
  logic [11:0]      set_radius;
  logic [1:0]       set_mode;
  logic             set_busy = 1'b0;
  logic             set_valid = 1'b0;
  logic [7:0]       set_candidate = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [7:0]       res_candidate;
  logic [TAG_W-1:0] res_tag;
  logic             res_timeout;
  logic [15:0]      done_cnt;

  always #5 clk = ~clk;

  set_host #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_central   (job_central),
    .job_radius    (job_radius),
    .job_mode      (job_mode),
    .job_tag       (job_tag),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_mode      (set_mode),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_candidate (res_candidate),
    .res_tag       (res_tag),
    .res_timeout   (res_timeout),
    .done_cnt      (done_cnt)
  );

  int errs   = 0;
  int checks = 0;
  int en_cnt = 0;
  int exp_done = 0;
  int eng_hang = 0;
  int eng_lat  = 2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One bench cycle: inputs change and outputs are read just after the
  // falling edge, well away from the rising edge the DUT samples on.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Grid count over x,y in 0..15 for the three circles and the mode rule.
  function automatic int ref_count(input logic [23:0] c, input logic [11:0] r,
                                   input logic [1:0] m);
    int n = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        int hits;
        bit hit [3];
        hits = 0;
        for (int k = 0; k < 3; k++) begin
          int cx, cy, rr;
          cx = int'(c[23-8*k -: 4]);
          cy = int'(c[19-8*k -: 4]);
          rr = int'(r[11-4*k -: 4]);
          hit[k] = ((x-cx)*(x-cx) + (y-cy)*(y-cy)) <= rr*rr;
          hits += int'(hit[k]);
        end
        case (m)
          2'd0:    n += int'(hit[0]);
          2'd1:    n += int'(hit[0] && hit[1]);
          2'd2:    n += int'(hit[0] ^ hit[1]);
          default: n += int'(hits == 2);
        endcase
      end
    end
    return n;
  endfunction

  always @(posedge clk) if (set_en) en_cnt <= en_cnt + 1;

  // Engine stub: busy 1..2 cycles after set_en, valid for one cycle after
  // eng_lat busy cycles, busy drops one cycle after valid. In hang mode it
  // stays silent past the watchdog, then holds busy for a while.
  initial begin
    forever begin
      @(negedge clk);
      if (set_en) begin
        if (eng_hang != 0) begin
          repeat (25) @(negedge clk);
          set_busy = 1'b1;
          repeat (8) @(negedge clk);
          set_busy = 1'b0;
        end else begin
          repeat ($urandom_range(1, 2)) @(negedge clk);
          set_busy = 1'b1;
          repeat (eng_lat) @(negedge clk);
          set_valid     = 1'b1;
          set_candidate = 8'(ref_count(set_central, set_radius, set_mode));
          @(negedge clk);
          set_valid     = 1'b0;
          set_candidate = 8'($urandom);
          @(negedge clk);
          set_busy = 1'b0;
        end
      end
    end
  end

  // Offer a job and wait for acceptance; returns with the bench one cycle
  // past the accepting edge (set_en should be high then).
  task automatic issue(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                       input logic [TAG_W-1:0] tg, output bit ok);
    int k = 0;
    job_central = c; job_radius = r; job_mode = m; job_tag = tg;
    job_valid = 1'b1;
    while (!job_ready && k < 100) begin step(); k++; end
    chk("job_ready_wait", 32'(job_ready), 32'd1);
    ok = job_ready;
    if (ok) step();
    job_valid   = 1'b0;
    job_central = 24'($urandom);
    job_radius  = 12'($urandom);
    job_mode    = 2'($urandom);
    job_tag     = TAG_W'($urandom);
  endtask

  // Full job: issue, follow to result, hold for 'hold' cycles, consume.
  task automatic do_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                        input logic [TAG_W-1:0] tg, input int hold, input bit to,
                        input int exp_fixed);
    int k, kv, en0, exp_cnt;
    bit ok, stable, held;
    logic [7:0] hc; logic [TAG_W-1:0] ht; logic hto;
    exp_cnt = to ? 0 : (exp_fixed >= 0 ? exp_fixed : ref_count(c, r, m) % 256);
    en0 = en_cnt;
    issue(c, r, m, tg, ok);
    if (!ok) return;
    chk("set_en_high", 32'(set_en), 32'd1);
    k = 0; kv = -1; stable = 1'b1;
    while (!res_valid && k < 60) begin
      if (set_mode !== m || set_central !== c || set_radius !== r) stable = 1'b0;
      if (set_valid && kv < 0) kv = k;
      step(); k++;
    end
    chk("res_valid_wait", 32'(res_valid), 32'd1);
    chk("set_fields_stable", 32'(stable), 32'd1);
    if (to) chk("timeout_latency", 32'(k), 32'(TIMEOUT + 2));
    else    chk("valid_to_res", 32'(k), 32'(kv + 3));
    chk("res_candidate", 32'(res_candidate), 32'(exp_cnt));
    chk("res_tag", 32'(res_tag), 32'(tg));
    chk("res_timeout", 32'(res_timeout), 32'(to));
    chk("set_en_once", 32'(en_cnt - en0), 32'd1);
    // Hold the result while another job is offered; nothing may move.
    hc = res_candidate; ht = res_tag; hto = res_timeout; held = 1'b1;
    job_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      step();
      if (!res_valid || res_candidate !== hc || res_tag !== ht ||
          res_timeout !== hto || job_ready !== 1'b0) held = 1'b0;
    end
    if (hold > 0) chk("result_held", 32'(held), 32'd1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    job_valid = 1'b0;
    exp_done = (exp_done + 1) % 65536;
    chk("done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    step();
    if (!to) chk("no_extra_set_en", 32'(en_cnt - en0), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit ok, quiet, seen, busy_ok;
    int k;
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_set_en", 32'(set_en), 32'd0);
    chk("rst_set_central", 32'(set_central), 32'd0);
    chk("rst_set_mode", 32'(set_mode), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_job_ready", 32'(job_ready), 32'd1);

    // Directed jobs with known counts
    eng_lat = 3;
    do_job(24'h440000, 12'h300, 2'd0, 4'd5, 0, 1'b0, 29);
    do_job(24'h444400, 12'h330, 2'd1, 4'd6, 1, 1'b0, 29);
    do_job(24'h444400, 12'h330, 2'd2, 4'd7, 0, 1'b0, 0);
    do_job(24'h444488, 12'h333, 2'd3, 4'd8, 2, 1'b0, -1);
    // Result held for 10 cycles while another job is offered
    do_job(24'h8877aa, 12'h524, 2'd3, 4'd9, 10, 1'b0, -1);

    // Hung engine: watchdog abort, then no job while engine reports busy
    eng_hang = 1;
    do_job(24'h123456, 12'h345, 2'd0, 4'd10, 5, 1'b1, 0);
    eng_hang = 0;
    k = 0;
    while (!set_busy && k < 20) begin step(); k++; end
    chk("late_busy_seen", 32'(set_busy), 32'd1);
    job_valid = 1'b1;
    busy_ok = 1'b1;
    k = 0;
    while (set_busy && k < 20) begin
      if (job_ready !== 1'b0 || set_en !== 1'b0) busy_ok = 1'b0;
      step(); k++;
    end
    job_valid = 1'b0;
    chk("blocked_while_busy", 32'(busy_ok), 32'd1);
    step();

    // Reset in WAIT_VALID abandons the job
    eng_lat = 8;
    issue(24'h556677, 12'h456, 2'd1, 4'd3, ok);
    k = 0;
    while (!set_busy && k < 10) begin step(); k++; end
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_set_en", 32'(set_en), 32'd0);
    chk("mid_rst_set_central", 32'(set_central), 32'd0);
    chk("mid_rst_set_radius", 32'(set_radius), 32'd0);
    chk("mid_rst_set_mode", 32'(set_mode), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_res_cand", 32'(res_candidate), 32'd0);
    chk("mid_rst_res_tag", 32'(res_tag), 32'd0);
    chk("mid_rst_res_to", 32'(res_timeout), 32'd0);
    chk("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
    exp_done = 0;
    quiet = 1'b1; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid || set_en) quiet = 1'b0;
      step();
    end
    chk("no_result_after_rst", 32'(quiet), 32'd1);
    do_job(24'h440000, 12'h300, 2'd0, 4'd11, 0, 1'b0, 29);

    // Randomized jobs
    for (int n = 0; n < 25; n++) begin
      eng_lat = $urandom_range(1, 8);
      do_job(24'($urandom), 12'($urandom), 2'($urandom_range(0, 3)),
             TAG_W'($urandom), $urandom_range(0, 3), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/set_host.md
# set_host

Job-issuing front end for the SET grid-candidate counting engine. It accepts job descriptors (three circle centres, three radii, mode) over a valid/ready interface, drives the engine's `en`/`central`/`radius`/`mode` inputs, and tracks the engine's `busy`/`valid` handshake. It captures `candidate` and returns it with a tag over a valid/ready result interface. A watchdog converts a hung engine into a flagged result.

## Interface
Parameters:
- TAG_W, 4, width of job/result tag
- TIMEOUT, 255, max cycles from `set_en` to engine completion before abort (≥2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- job_valid  in  1  job descriptor present
- job_ready  out  1  block can accept job
- job_central  in  24  {x1,y1,x2,y2,x3,y3}, 4 bits each, MSB first
- job_radius  in  12  {r1,r2,r3}
- job_mode  in  2  0: in C1; 1: C1∩C2; 2: C1 xor C2; 3: in exactly two of C1,C2,C3
- job_tag  in  TAG_W  returned with result
- set_en  out  1  one-cycle job start to engine
- set_central  out  24  registered copy of job_central
- set_radius  out  12  registered copy of job_radius
- set_mode  out  2  registered copy of job_mode
- set_busy  in  1  engine busy
- set_valid  in  1  engine result valid
- set_candidate  in  8  engine count
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_candidate  out  8  captured count (0 on timeout)
- res_tag  out  TAG_W  tag of job
- res_timeout  out  1  job aborted by watchdog
- done_cnt  out  16  results handed off since reset, wraps at 0xFFFF→0

## Operation
FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_VALID, DRAIN, RESULT.
- IDLE: job_ready = !set_busy. Accept when job_valid && job_ready; latch central/radius/mode/tag into set_* and tag registers; → ISSUE.
- ISSUE: set_en=1 (only state where it is high); clear watchdog; → WAIT_BUSY.
- WAIT_BUSY: set_busy=1 → WAIT_VALID. set_valid ignored here.
- WAIT_VALID: set_valid=1 → capture set_candidate into res_candidate, res_timeout=0; → DRAIN.
- DRAIN: set_busy=0 → RESULT.
- RESULT: res_valid=1; on res_ready → done_cnt+1, → IDLE.
- Watchdog: counts each cycle in WAIT_BUSY/WAIT_VALID/DRAIN. When it reaches TIMEOUT → res_candidate=0, res_timeout=1, → RESULT.
- set_mode, set_central, set_radius change only on job acceptance. The engine samples mode every cycle, so these must stay stable for the whole job and afterward.
- One job in flight. No new job is accepted while a result is unconsumed or the engine still reports busy, including after a timeout.

## Timing
- Reset: all outputs 0 and state IDLE one cycle after rst is sampled high. job_ready may then follow !set_busy. Reset mid-job abandons the job with no result and no set_en reissue.
- Job accepted at edge T → set_en high during cycle T+1 only.
- set_valid first sampled high at edge V → res_valid high from V+2, given the engine drops busy one cycle after valid. Otherwise res_valid follows set_busy falling.
- res_valid, res_candidate, res_tag, res_timeout hold stable until res_ready is sampled high.
- A job offered in the same cycle a result is consumed is not accepted; job_ready is low in RESULT. Minimum job-to-job spacing is therefore one IDLE cycle.
- Timeout: watchdog reaches TIMEOUT exactly TIMEOUT cycles after leaving ISSUE → res_valid asserted next cycle.
- Widths: res_candidate is a straight 8-bit capture; done_cnt wraps modulo 2^16.

## Structure
- Package set_pkg: state enum, MODE_* constants (0..3), field widths (coordinate 4, central 24, radius 12, count 8).
- Sub-module set_watchdog: clear/enable/expire counter parameterised by TIMEOUT. Shared later with other engine hosts.

## Test plan
- Mode 0, central 0x440000, radius 0x300, tag 5, against real SET → res_candidate=29, res_tag=5, res_timeout=0, set_en high exactly 1 cycle.
- Mode 1, central 0x444400, radius 0x330 → 29. Same job with mode 2 → 0.
- Mode 3, central 0x444488, radius 0x333: compare with bench reference model; set_mode stable from acceptance through res_valid.
- Engine stub never raises busy, TIMEOUT=20 → res_valid 22 cycles after acceptance, res_timeout=1, res_candidate=0; job_ready stays low while the stub later holds busy high.
- res_ready held low 10 cycles after res_valid → outputs held constant, job_ready=0, no second set_en; on release done_cnt increments by 1.
- rst pulsed during WAIT_VALID → next cycle all outputs 0, no result produced; the following job completes normally.
